rggen_register_bus_initiator: RTL



---
 rtl/rggen_register_bus_initiator_pkg.sv | 31 +++
 rtl/rggen_bus_timeout_counter.sv | 29 ++
 rtl/rggen_register_bus_initiator.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rggen_register_bus_initiator_pkg.sv
// Shared encodings and FSM state type for the register bus initiator.
// The responder side uses the same access and status codes.
package rggen_register_bus_initiator_pkg;

    localparam logic [1:0] ACCESS_POSTED_WRITE = 2'b01;
    localparam logic [1:0] ACCESS_READ         = 2'b10;
    localparam logic [1:0] ACCESS_WRITE        = 2'b11;

    localparam logic [1:0] STATUS_OKAY   = 2'b00;
    localparam logic [1:0] STATUS_EXOKAY = 2'b01;
    localparam logic [1:0] STATUS_SLVERR = 2'b10;
    localparam logic [1:0] STATUS_DECERR = 2'b11;

    typedef enum logic [1:0] {
        STATE_IDLE    = 2'd0,
        STATE_BUSY    = 2'd1,
        STATE_RESPOND = 2'd2
    } state_e;

    function automatic logic is_legal_access(input logic [1:0] access);
        return (access == ACCESS_READ) || (access == ACCESS_WRITE) ||
               (access == ACCESS_POSTED_WRITE);
    endfunction

    // Read data is only forwarded for reads that completed without error.
    function automatic logic has_read_data(input logic [1:0] access, input logic [1:0] status);
        return (access == ACCESS_READ) &&
               ((status == STATUS_OKAY) || (status == STATUS_EXOKAY));
    endfunction

endpackage

// File: rtl/rggen_bus_timeout_counter.sv
// Saturating wait-cycle counter for the register bus initiator.
// Expired asserts once LIMIT cycles have been counted; LIMIT = 0 disables it.
module rggen_bus_timeout_counter #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 0
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [WIDTH-1:0] LIMIT_VALUE = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            count <= '0;
        end else if (i_enable && (count != LIMIT_VALUE)) begin
            count <= count + 1'b1;
        end
    end

    // The cycle that sees count == LIMIT is the (LIMIT+1)-th waiting cycle.
    assign o_expired = (LIMIT != 0) && (count == LIMIT_VALUE);

endmodule

// File: rtl/rggen_register_bus_initiator.sv
// Register bus initiator: one command at a time from a valid/ready front end,
// drives the responder array and returns a registered response.
//
// state   | meaning
// IDLE    | ready for a command, no bus request
// BUSY    | bus request held, waiting for ready / inactive / timeout
// RESPOND | response valid, waiting for the consumer
module rggen_register_bus_initiator
    import rggen_register_bus_initiator_pkg::*;
#(
    parameter int ADDRESS_WIDTH         = 8,
    parameter int BUS_WIDTH             = 32,
    parameter int TIMEOUT_CYCLES        = 0,
    parameter int TIMEOUT_COUNTER_WIDTH = 8
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [1:0]               i_cmd_access,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
    input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
    input  logic [BUS_WIDTH-1:0]     i_cmd_strobe,
    output logic                     o_register_valid,
    output logic [1:0]               o_register_access,
    output logic [ADDRESS_WIDTH-1:0] o_register_address,
    output logic [BUS_WIDTH-1:0]     o_register_write_data,
    output logic [BUS_WIDTH-1:0]     o_register_strobe,
    input  logic                     i_register_active,
    input  logic                     i_register_ready,
    input  logic [1:0]               i_register_status,
    input  logic [BUS_WIDTH-1:0]     i_register_read_data,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [1:0]               o_rsp_status,
    output logic [BUS_WIDTH-1:0]     o_rsp_read_data
);

    state_e state;
    state_e state_next;
    logic   timeout_expired;

    rggen_bus_timeout_counter #(
        .WIDTH (TIMEOUT_COUNTER_WIDTH),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (state != STATE_BUSY),
        .i_enable  (state == STATE_BUSY),
        .o_expired (timeout_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            STATE_IDLE: begin
                if (i_cmd_valid) begin
                    state_next = is_legal_access(i_cmd_access) ? STATE_BUSY : STATE_RESPOND;
                end
            end
            STATE_BUSY: begin
                if (i_register_ready || !i_register_active || timeout_expired) begin
                    state_next = STATE_RESPOND;
                end
            end
            STATE_RESPOND: begin
                if (i_rsp_ready) begin
                    state_next = STATE_IDLE;
                end
            end
            default: state_next = STATE_IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ready      = 1'b0;
        o_register_valid = 1'b0;
        o_rsp_valid      = 1'b0;
        case (state)
            STATE_IDLE:    o_cmd_ready      = 1'b1;
            STATE_BUSY:    o_register_valid = 1'b1;
            STATE_RESPOND: o_rsp_valid      = 1'b1;
            default:       o_cmd_ready      = 1'b0;
        endcase
    end

    // Bus fields and response are only written on state-changing cycles,
    // so they stay stable while BUSY or RESPOND is held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_register_access     <= '0;
            o_register_address    <= '0;
            o_register_write_data <= '0;
            o_register_strobe     <= '0;
            o_rsp_status          <= '0;
            o_rsp_read_data       <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (i_cmd_valid) begin
                        if (is_legal_access(i_cmd_access)) begin
                            o_register_access     <= i_cmd_access;
                            o_register_address    <= i_cmd_address;
                            o_register_write_data <= i_cmd_write_data;
                            o_register_strobe     <= i_cmd_strobe;
                        end else begin
                            o_rsp_status    <= STATUS_SLVERR;
                            o_rsp_read_data <= '0;
                        end
                    end
                end
                STATE_BUSY: begin
                    if (i_register_ready) begin
                        o_rsp_status    <= i_register_status;
                        o_rsp_read_data <= has_read_data(o_register_access, i_register_status)
                                           ? i_register_read_data : '0;
                    end else if (!i_register_active) begin
                        o_rsp_status    <= STATUS_DECERR;
                        o_rsp_read_data <= '0;
                    end else if (timeout_expired) begin
                        o_rsp_status    <= STATUS_SLVERR;
                        o_rsp_read_data <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
